conv2d_linebuf: RTL

Streaming K×K 2-D convolution engine for the video path. It is the parametrised successor to the fixed-kernel convolution stage.
- Line buffers are K−1 RAM rows rather than a full-frame shift register.
- NKERN runtime-writable coefficient banks are selected per frame.
- Border handling, round-to-nearest and saturation are explicit.
- dstream backpressure is honoured end to end.
- It sits between the pixel source and the display/output formatter and emits exactly one output per input pixel.

---
 rtl/conv2d_linebuf_if.sv | 12 +
 rtl/conv2d_linebuf.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_linebuf_if.sv
// Valid/ready pixel stream between video-path stages; master drives data/valid,
// slave drives ready.
interface conv2d_linebuf_if #(
    parameter int W = 32
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/conv2d_linebuf.sv
// Streaming KxK 2-D correlation: K-1 line-buffer RAMs, per-frame coefficient bank,
// border masking, round-to-nearest and saturation, 3-stage pipeline with backpressure.
module conv2d_linebuf #(
    parameter int W      = 32,
    parameter int W_FRAC = 16,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int K      = 5,
    parameter int NKERN  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NKERN)-1:0] kern_sel,
    input  logic                     border_mode,
    input  logic                     coef_we,
    input  logic [$clog2(NKERN)-1:0] coef_bank,
    input  logic [$clog2(K*K)-1:0]   coef_tap,
    input  logic [W-1:0]             coef_data,
    conv2d_linebuf_if.slave          x,
    conv2d_linebuf_if.master         y,
    output logic                     frame_done,
    output logic                     overflow
);
    localparam int NT  = K * K;
    localparam int CW  = $clog2(WIDTH);
    localparam int RW  = $clog2(HEIGHT);
    localparam int BW  = $clog2(NKERN);
    localparam int TW  = $clog2(NT);
    localparam int PW  = 2 * W;
    localparam int SW  = 2 * W + TW + 1;
    localparam int CTR = ((K - 1) / 2) * K + (K - 1) / 2;

    localparam logic [W-1:0]         ONE_COEF    = {{(W-1){1'b0}}, 1'b1} << W_FRAC;
    localparam logic signed [SW-1:0] RND         = {{(SW-1){1'b0}}, 1'b1} << (W_FRAC - 1);
    localparam logic [W-1:0]         SAT_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         SAT_MIN     = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [SW-1:0] SAT_MAX_EXT = {{(SW-W){1'b0}}, SAT_MAX};
    localparam logic signed [SW-1:0] SAT_MIN_EXT = {{(SW-W){1'b1}}, SAT_MIN};

    function automatic logic signed [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        ae = {{W{a[W-1]}}, a};
        be = {{W{b[W-1]}}, b};
        return ae * be;
    endfunction

    // Position, frame-latched controls and coefficient storage
    logic [CW-1:0]  col_r;
    logic [RW-1:0]  row_r;
    logic [BW-1:0]  kern_r;
    logic           bmode_r;
    logic [W-1:0]   coef_r [NKERN][NT];

    // Line buffers and sliding window (not reset; stale data falls under the border rule)
    logic [W-1:0]   lb_mem [K-1][WIDTH];
    logic [W-1:0]   win_r  [K][K];

    // Pipeline stage registers
    logic                 s1_v_r;
    logic signed [PW-1:0] s1_prod_r [NT];
    logic [W-1:0]         s1_pix_r;
    logic                 s1_int_r;
    logic                 s1_bmode_r;
    logic                 s1_last_r;
    logic                 s2_v_r;
    logic signed [SW-1:0] s2_sum_r;
    logic [W-1:0]         s2_pix_r;
    logic                 s2_int_r;
    logic                 s2_bmode_r;
    logic                 s2_last_r;
    logic                 y_valid_r;
    logic [W-1:0]         y_data_r;
    logic                 y_last_r;
    logic                 frame_done_r;
    logic                 overflow_r;

    // Combinational signals
    logic                 advance_s;
    logic                 x_fire_s;
    logic                 frame_start_s;
    logic                 last_s;
    logic                 interior_s;
    logic [BW-1:0]        kern_eff_s;
    logic                 bmode_eff_s;
    logic [CW-1:0]        col_nx_s;
    logic [RW-1:0]        row_nx_s;
    logic [W-1:0]         lb_rd_s    [K-1];
    logic [W-1:0]         new_col_s  [K];
    logic [W-1:0]         win_nx_s   [K][K];
    logic signed [PW-1:0] prod_s     [NT];
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] rnd_s;
    logic signed [SW-1:0] shr_s;
    logic [W-1:0]         res_s;
    logic                 sat_s;
    logic [W-1:0]         out_s;
    logic                 out_sat_s;

    assign advance_s     = y.ready | ~y_valid_r;
    assign x_fire_s      = x.valid & advance_s;
    assign x.ready       = advance_s;
    assign y.valid       = y_valid_r;
    assign y.data        = y_data_r;
    assign frame_done    = frame_done_r;
    assign overflow      = overflow_r;
    assign frame_start_s = (col_r == {CW{1'b0}}) && (row_r == {RW{1'b0}});
    assign last_s        = (col_r == CW'(WIDTH - 1)) && (row_r == RW'(HEIGHT - 1));
    assign interior_s    = (row_r >= RW'(K - 1)) && (col_r >= CW'(K - 1));

    // Raster position advance with line and frame wrap
    always_comb begin
        col_nx_s = col_r;
        row_nx_s = row_r;
        if (col_r == CW'(WIDTH - 1)) begin
            col_nx_s = {CW{1'b0}};
            if (row_r == RW'(HEIGHT - 1)) begin
                row_nx_s = {RW{1'b0}};
            end else begin
                row_nx_s = row_r + RW'(1'b1);
            end
        end else begin
            col_nx_s = col_r + CW'(1'b1);
        end
    end

    // The (0,0) pixel already uses the controls being latched for its frame
    always_comb begin
        kern_eff_s  = kern_r;
        bmode_eff_s = bmode_r;
        if (frame_start_s) begin
            kern_eff_s  = kern_sel;
            bmode_eff_s = border_mode;
        end else begin
            kern_eff_s  = kern_r;
            bmode_eff_s = bmode_r;
        end
    end

    // Read-before-write line-buffer column, shifted window and tap products
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            lb_rd_s[i] = lb_mem[i][col_r];
        end
        new_col_s[K-1] = x.data;
        for (int r = 0; r < K - 1; r++) begin
            new_col_s[r] = lb_rd_s[K-2-r];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_nx_s[r][c] = win_r[r][c+1];
            end
            win_nx_s[r][K-1] = new_col_s[r];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod_s[r*K+c] = smul(win_nx_s[r][c], coef_r[kern_eff_s][r*K+c]);
            end
        end
    end

    // Adder tree over the S1 products
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int i = 0; i < NT; i++) begin
            sum_s = sum_s + {{(SW-PW){s1_prod_r[i][PW-1]}}, s1_prod_r[i]};
        end
    end

    // Round half-up, drop fraction, clamp to signed W
    always_comb begin
        rnd_s = s2_sum_r + RND;
        shr_s = rnd_s >>> W_FRAC;
        res_s = shr_s[W-1:0];
        sat_s = 1'b0;
        if (shr_s > SAT_MAX_EXT) begin
            res_s = SAT_MAX;
            sat_s = 1'b1;
        end else if (shr_s < SAT_MIN_EXT) begin
            res_s = SAT_MIN;
            sat_s = 1'b1;
        end else begin
            res_s = shr_s[W-1:0];
            sat_s = 1'b0;
        end
    end

    // Border outputs bypass arithmetic and never flag overflow
    always_comb begin
        out_s     = {W{1'b0}};
        out_sat_s = 1'b0;
        if (s2_int_r) begin
            out_s     = res_s;
            out_sat_s = sat_s;
        end else if (s2_bmode_r) begin
            out_s = s2_pix_r;
        end else begin
            out_s = {W{1'b0}};
        end
    end

    // Coefficient banks: identity on reset, runtime writes otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NKERN; b++) begin
                for (int t = 0; t < NT; t++) begin
                    coef_r[b][t] <= (t == CTR) ? ONE_COEF : {W{1'b0}};
                end
            end
        end else if (coef_we && (coef_tap < TW'(NT))) begin
            coef_r[coef_bank][coef_tap] <= coef_data;
        end
    end

    // Line-buffer cascade and window shift on each accepted pixel
    always_ff @(posedge clk) begin
        if (x_fire_s) begin
            lb_mem[0][col_r] <= x.data;
            for (int i = 1; i < K - 1; i++) begin
                lb_mem[i][col_r] <= lb_rd_s[i-1];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_r[r][c] <= win_nx_s[r][c];
                end
            end
        end
    end

    // Stage payloads move only when the whole pipe advances
    always_ff @(posedge clk) begin
        if (x_fire_s) begin
            for (int i = 0; i < NT; i++) begin
                s1_prod_r[i] <= prod_s[i];
            end
            s1_pix_r   <= x.data;
            s1_int_r   <= interior_s;
            s1_bmode_r <= bmode_eff_s;
            s1_last_r  <= last_s;
        end
        if (advance_s) begin
            s2_sum_r   <= sum_s;
            s2_pix_r   <= s1_pix_r;
            s2_int_r   <= s1_int_r;
            s2_bmode_r <= s1_bmode_r;
            s2_last_r  <= s1_last_r;
        end
    end

    // Control state: position, frame latches, valids, output register, flags
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
            kern_r       <= {BW{1'b0}};
            bmode_r      <= 1'b0;
            s1_v_r       <= 1'b0;
            s2_v_r       <= 1'b0;
            y_valid_r    <= 1'b0;
            y_data_r     <= {W{1'b0}};
            y_last_r     <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (x_fire_s) begin
                col_r <= col_nx_s;
                row_r <= row_nx_s;
                if (frame_start_s) begin
                    kern_r  <= kern_sel;
                    bmode_r <= border_mode;
                end
            end
            if (advance_s) begin
                s1_v_r    <= x_fire_s;
                s2_v_r    <= s1_v_r;
                y_valid_r <= s2_v_r;
                if (s2_v_r) begin
                    y_data_r <= out_s;
                    y_last_r <= s2_last_r;
                    if (out_sat_s) begin
                        overflow_r <= 1'b1;
                    end
                end
            end
            frame_done_r <= y_valid_r & y.ready & y_last_r;
        end
    end
endmodule
